// File: rtl/md_scoreboard_hazard_unit.sv
// Hazard unit for the FD/DX/XM/WB pipeline: load-use stalls, one outstanding
// multi-cycle mult/div tracked IDLE -> BUSY -> DONE, and a saturating stall counter.
module md_scoreboard_hazard_unit #(
    parameter int REG_W          = 5,
    parameter int STATUS_REG     = 30,
    parameter int LINK_REG       = 31,
    parameter int MD_NONBLOCKING = 0,
    parameter int CNT_W          = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [31:0]      fd_instr,
    input  logic [31:0]      dx_instr,
    input  logic             flush,
    input  logic             md_ready,
    input  logic             md_exception,
    input  logic             cnt_clear,
    output logic             stall_fd,
    output logic             bubble_dx,
    output logic             md_start,
    output logic             md_wb_valid,
    output logic [REG_W-1:0] md_wb_rd,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_count,
    output logic [1:0]       dbg_state
);

    localparam logic [4:0] OP_RTYPE = 5'd0;
    localparam logic [4:0] OP_JAL   = 5'd3;
    localparam logic [4:0] OP_BNE   = 5'd2;
    localparam logic [4:0] OP_JR    = 5'd4;
    localparam logic [4:0] OP_ADDI  = 5'd5;
    localparam logic [4:0] OP_BLT   = 5'd6;
    localparam logic [4:0] OP_SW    = 5'd7;
    localparam logic [4:0] OP_LW    = 5'd8;
    localparam logic [4:0] OP_SETX  = 5'd21;
    localparam logic [4:0] OP_BEX   = 5'd22;
    localparam logic [4:0] ALU_MUL  = 5'd6;
    localparam logic [4:0] ALU_DIV  = 5'd7;

    localparam logic [REG_W-1:0] STATUS_IDX = REG_W'(STATUS_REG);
    localparam logic [REG_W-1:0] LINK_IDX   = REG_W'(LINK_REG);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic             is_md;
        logic             rd_a_v;
        logic [REG_W-1:0] rd_a;
        logic             rd_b_v;
        logic [REG_W-1:0] rd_b;
        logic             wr_v;
        logic [REG_W-1:0] wr;
    } dec_t;

    // Register-usage decode; register 0 is folded out so it never matches.
    function automatic dec_t decode_instr(input logic [31:0] instr);
        dec_t             d;
        logic [4:0]       op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        op = instr[31:27];
        rd = instr[22 +: REG_W];
        rs = instr[17 +: REG_W];
        rt = instr[12 +: REG_W];
        d  = '0;
        case (op)
            OP_RTYPE: begin
                d.rd_a_v = 1'b1; d.rd_a = rs;
                d.rd_b_v = 1'b1; d.rd_b = rt;
                d.wr_v   = 1'b1; d.wr   = rd;
                d.is_md  = (instr[6:2] == ALU_MUL) || (instr[6:2] == ALU_DIV);
            end
            OP_ADDI, OP_LW: begin
                d.rd_a_v = 1'b1; d.rd_a = rs;
                d.wr_v   = 1'b1; d.wr   = rd;
            end
            OP_SW: begin
                d.rd_a_v = 1'b1; d.rd_a = rs;
                d.rd_b_v = 1'b1; d.rd_b = rd;
            end
            OP_BNE, OP_BLT: begin
                d.rd_a_v = 1'b1; d.rd_a = rd;
                d.rd_b_v = 1'b1; d.rd_b = rs;
            end
            OP_JR: begin
                d.rd_a_v = 1'b1; d.rd_a = rd;
            end
            OP_BEX: begin
                d.rd_a_v = 1'b1; d.rd_a = STATUS_IDX;
            end
            OP_JAL: begin
                d.wr_v = 1'b1; d.wr = LINK_IDX;
            end
            OP_SETX: begin
                d.wr_v = 1'b1; d.wr = STATUS_IDX;
            end
            default: d = '0;
        endcase
        d.rd_a_v = d.rd_a_v && (d.rd_a != '0);
        d.rd_b_v = d.rd_b_v && (d.rd_b != '0);
        d.wr_v   = d.wr_v && (d.wr != '0);
        return d;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [REG_W-1:0] r_md_rd;
    logic [REG_W-1:0] w_md_rd_nxt;
    logic             r_exc_q;
    logic             w_exc_nxt;
    logic [CNT_W-1:0] r_cnt;

    dec_t             w_fd;
    logic [4:0]       w_dx_op;
    logic [REG_W-1:0] w_dx_rd;
    logic             w_dx_is_lw;
    logic             w_dx_is_md;
    logic             w_load_use;
    logic             w_fd_dep;
    logic             w_pre_stall;
    logic             w_md_start;
    logic             w_wb_valid;
    logic [REG_W-1:0] w_wb_rd;
    logic             w_stall;
    logic             w_unused;

    assign w_fd       = decode_instr(fd_instr);
    assign w_dx_op    = dx_instr[31:27];
    assign w_dx_rd    = dx_instr[22 +: REG_W];
    assign w_dx_is_lw = (w_dx_op == OP_LW);
    assign w_dx_is_md = (w_dx_op == OP_RTYPE) &&
                        ((dx_instr[6:2] == ALU_MUL) || (dx_instr[6:2] == ALU_DIV));

    assign w_unused = ^{dx_instr[21:7], dx_instr[1:0], fd_instr[11:7], fd_instr[1:0]};

    assign w_load_use = w_dx_is_lw && (w_dx_rd != '0) &&
                        ((w_fd.rd_a_v && (w_fd.rd_a == w_dx_rd)) ||
                         (w_fd.rd_b_v && (w_fd.rd_b == w_dx_rd)));

    // Dependents of the in-flight md op: its destination, rstatus (where an
    // exception lands), or a second md competing for the unit.
    assign w_fd_dep = (w_fd.rd_a_v && ((w_fd.rd_a == r_md_rd) || (w_fd.rd_a == STATUS_IDX))) ||
                      (w_fd.rd_b_v && ((w_fd.rd_b == r_md_rd) || (w_fd.rd_b == STATUS_IDX))) ||
                      (w_fd.wr_v   && ((w_fd.wr   == r_md_rd) || (w_fd.wr   == STATUS_IDX))) ||
                      w_fd.is_md;

    always_comb begin
        w_pre_stall = w_load_use;
        if (r_state == S_BUSY) begin
            w_pre_stall = w_pre_stall || ((MD_NONBLOCKING != 0) ? w_fd_dep : 1'b1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_md_rd_nxt = r_md_rd;
        w_exc_nxt   = r_exc_q;
        w_md_start  = 1'b0;
        w_wb_valid  = 1'b0;
        w_wb_rd     = '0;
        case (r_state)
            S_IDLE: begin
                w_md_start = w_dx_is_md && !flush && !w_pre_stall;
                if (w_md_start) begin
                    w_state_nxt = S_BUSY;
                    w_md_rd_nxt = w_dx_rd;
                end
            end
            S_BUSY: begin
                if (md_ready) begin
                    w_state_nxt = S_DONE;
                    w_exc_nxt   = md_exception;
                end
            end
            S_DONE: begin
                w_wb_valid  = 1'b1;
                w_wb_rd     = r_exc_q ? STATUS_IDX : r_md_rd;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The blocking mode also freezes the cycle the md op leaves DX.
    assign w_stall = !flush && (w_pre_stall || ((MD_NONBLOCKING == 0) && w_md_start));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_md_rd <= '0;
            r_exc_q <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_md_rd <= w_md_rd_nxt;
            r_exc_q <= w_exc_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (cnt_clear) begin
            r_cnt <= '0;
        end else if (w_stall && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign stall_fd    = reset_n && w_stall;
    assign bubble_dx   = reset_n && w_stall;
    assign md_start    = reset_n && w_md_start;
    assign md_wb_valid = reset_n && w_wb_valid;
    assign md_wb_rd    = reset_n ? w_wb_rd : '0;
    assign md_busy     = (r_state != S_IDLE);
    assign stall_count = r_cnt;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_md_scoreboard_hazard_unit.sv
// Bench for md_scoreboard_hazard_unit: three configurations driven in parallel
// and compared every cycle against a register-usage reference model.
module tb_md_scoreboard_hazard_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] fd_instr = '0;
  logic [31:0] dx_instr = '0;
  logic        flush = 1'b0;
  logic        md_ready = 1'b0;
  logic        md_exception = 1'b0;
  logic        cnt_clear = 1'b0;

  logic        s0_stall, s0_bub, s0_start, s0_wbv, s0_busy;
  logic [4:0]  s0_wbrd;
  logic [15:0] s0_cnt;
  logic [1:0]  s0_dbg;
  logic        s1_stall, s1_bub, s1_start, s1_wbv, s1_busy;
  logic [4:0]  s1_wbrd;
  logic [15:0] s1_cnt;
  logic [1:0]  s1_dbg;
  logic        s2_stall, s2_bub, s2_start, s2_wbv, s2_busy;
  logic [4:0]  s2_wbrd;
  logic [1:0]  s2_cnt;
  logic [1:0]  s2_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state, one slot per configuration
  bit m_inflight[3];
  bit m_wb[3];
  bit m_exc[3];
  int m_rd[3];
  int m_cnt[3];
  int nb_mode[3] = '{0, 1, 0};
  int cnt_max[3] = '{65535, 65535, 3};

  always #5 clock = ~clock;

  md_scoreboard_hazard_unit #(.MD_NONBLOCKING(0), .CNT_W(16)) u_nb0 (
    .clock(clock), .reset_n(reset_n), .fd_instr(fd_instr), .dx_instr(dx_instr),
    .flush(flush), .md_ready(md_ready), .md_exception(md_exception), .cnt_clear(cnt_clear),
    .stall_fd(s0_stall), .bubble_dx(s0_bub), .md_start(s0_start), .md_wb_valid(s0_wbv),
    .md_wb_rd(s0_wbrd), .md_busy(s0_busy), .stall_count(s0_cnt), .dbg_state(s0_dbg));

  md_scoreboard_hazard_unit #(.MD_NONBLOCKING(1), .CNT_W(16)) u_nb1 (
    .clock(clock), .reset_n(reset_n), .fd_instr(fd_instr), .dx_instr(dx_instr),
    .flush(flush), .md_ready(md_ready), .md_exception(md_exception), .cnt_clear(cnt_clear),
    .stall_fd(s1_stall), .bubble_dx(s1_bub), .md_start(s1_start), .md_wb_valid(s1_wbv),
    .md_wb_rd(s1_wbrd), .md_busy(s1_busy), .stall_count(s1_cnt), .dbg_state(s1_dbg));

  md_scoreboard_hazard_unit #(.MD_NONBLOCKING(0), .CNT_W(2)) u_c2 (
    .clock(clock), .reset_n(reset_n), .fd_instr(fd_instr), .dx_instr(dx_instr),
    .flush(flush), .md_ready(md_ready), .md_exception(md_exception), .cnt_clear(cnt_clear),
    .stall_fd(s2_stall), .bubble_dx(s2_bub), .md_start(s2_start), .md_wb_valid(s2_wbv),
    .md_wb_rd(s2_wbrd), .md_busy(s2_busy), .stall_count(s2_cnt), .dbg_state(s2_dbg));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs(input int k, input int i);
    logic [31:0] v [8];
    case (k)
      0: v = '{32'(s0_stall), 32'(s0_bub), 32'(s0_start), 32'(s0_wbv), 32'(s0_wbrd),
               32'(s0_busy), 32'(s0_cnt), 32'(s0_dbg != 2'd0)};
      1: v = '{32'(s1_stall), 32'(s1_bub), 32'(s1_start), 32'(s1_wbv), 32'(s1_wbrd),
               32'(s1_busy), 32'(s1_cnt), 32'(s1_dbg != 2'd0)};
      default: v = '{32'(s2_stall), 32'(s2_bub), 32'(s2_start), 32'(s2_wbv), 32'(s2_wbrd),
               32'(s2_busy), 32'(s2_cnt), 32'(s2_dbg != 2'd0)};
    endcase
    return v[i];
  endfunction

  // Register usage straight from the ISA table; -1 means "no register involved".
  function automatic void usage(input logic [31:0] ins, output int ra, output int rb,
                                output int wr, output bit is_md, output bit is_lw);
    int op, rd, rs, rt, alu;
    op = int'(ins[31:27]); rd = int'(ins[26:22]); rs = int'(ins[21:17]);
    rt = int'(ins[16:12]); alu = int'(ins[6:2]);
    ra = -1; rb = -1; wr = -1; is_md = 1'b0; is_lw = (op == 8);
    case (op)
      0:    begin ra = rs; rb = rt; wr = rd; is_md = (alu == 6) || (alu == 7); end
      5, 8: begin ra = rs; wr = rd; end
      7:    begin ra = rs; rb = rd; end
      2, 6: begin ra = rd; rb = rs; end
      4:    ra = rd;
      22:   ra = 30;
      3:    wr = 31;
      21:   wr = 30;
      default: ;
    endcase
    if (ra == 0) ra = -1;
    if (rb == 0) rb = -1;
    if (wr == 0) wr = -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_inflight[k] = 1'b0; m_wb[k] = 1'b0; m_exc[k] = 1'b0; m_rd[k] = 0; m_cnt[k] = 0;
    end
  endtask

  // One clock: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic step();
    int fa, fb, fw, da, db, dw, drd;
    bit fmd, flw, dmd, dlw, lu, dep, start, stall;
    int exp_v [8];
    @(negedge clock);
    usage(fd_instr, fa, fb, fw, fmd, flw);
    usage(dx_instr, da, db, dw, dmd, dlw);
    drd = int'(dx_instr[26:22]);
    for (int k = 0; k < 3; k++) begin
      lu = dlw && (drd != 0) && (fa == drd || fb == drd);
      dep = 1'b0;
      if (m_inflight[k]) begin
        if (nb_mode[k] == 0) dep = 1'b1;
        else dep = (m_rd[k] != 0 && (fa == m_rd[k] || fb == m_rd[k] || fw == m_rd[k])) ||
                   fa == 30 || fb == 30 || fw == 30 || fmd;
      end
      start = !m_inflight[k] && !m_wb[k] && dmd && !flush && !lu;
      stall = !flush && (lu || dep || (nb_mode[k] == 0 && start));
      exp_v = '{int'(stall), int'(stall), int'(start), int'(m_wb[k]),
                m_wb[k] ? (m_exc[k] ? 30 : m_rd[k]) : 0,
                int'(m_inflight[k] || m_wb[k]), m_cnt[k], int'(m_inflight[k] || m_wb[k])};
      check($sformatf("u%0d.stall_fd", k),    obs(k, 0), 32'(exp_v[0]));
      check($sformatf("u%0d.bubble_dx", k),   obs(k, 1), 32'(exp_v[1]));
      check($sformatf("u%0d.md_start", k),    obs(k, 2), 32'(exp_v[2]));
      check($sformatf("u%0d.md_wb_valid", k), obs(k, 3), 32'(exp_v[3]));
      check($sformatf("u%0d.md_wb_rd", k),    obs(k, 4), 32'(exp_v[4]));
      check($sformatf("u%0d.md_busy", k),     obs(k, 5), 32'(exp_v[5]));
      check($sformatf("u%0d.stall_count", k), obs(k, 6), 32'(exp_v[6]));
      check($sformatf("u%0d.dbg_active", k),  obs(k, 7), 32'(exp_v[7]));
      if (m_wb[k]) m_wb[k] = 1'b0;
      else if (m_inflight[k] && md_ready) begin
        m_inflight[k] = 1'b0; m_wb[k] = 1'b1; m_exc[k] = md_exception;
      end
      if (start) begin m_inflight[k] = 1'b1; m_rd[k] = drd; end
      if (cnt_clear) m_cnt[k] = 0;
      else if (stall && m_cnt[k] < cnt_max[k]) m_cnt[k]++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 8; i++) check($sformatf("u%0d.reset_out%0d", k, i), obs(k, i), 32'd0);
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] alu);
    return {5'd0, rd, rs, rt, 5'd0, alu, 2'b00};
  endfunction

  function automatic logic [31:0] mk_i(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs);
    logic [16:0] imm;
    imm = 17'($urandom);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [4:0] rreg();
    case ($urandom_range(0, 7))
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd3;
      3: return 5'd6;
      4: return 5'd7;
      5: return 5'd30;
      6: return 5'd31;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  function automatic logic [31:0] rinstr();
    logic [4:0] a, b, c;
    a = rreg(); b = rreg(); c = rreg();
    case ($urandom_range(0, 12))
      0, 1: return mk_r(a, b, c, 5'($urandom_range(0, 5)));
      2:    return mk_r(a, b, c, 5'($urandom_range(6, 7)));
      3:    return mk_i(5'd5, a, b);
      4, 5: return mk_i(5'd8, a, b);
      6:    return mk_i(5'd7, a, b);
      7:    return mk_i(5'd2, a, b);
      8:    return mk_i(5'd6, a, b);
      9:    return mk_i(5'd4, a, b);
      10:   return mk_i(5'd22, a, b);
      11:   return mk_i(5'd3, a, b);
      default: return ($urandom_range(0, 1) != 0) ? mk_i(5'd21, a, b) : mk_i(5'd1, a, b);
    endcase
  endfunction

  initial begin
    int c0, c1;
    model_reset();
    do_reset();

    // load-use: lw r3 in DX, add r4,r3,r5 in FD
    dx_instr = mk_i(5'd8, 5'd3, 5'd1);
    fd_instr = mk_r(5'd4, 5'd3, 5'd5, 5'd0);
    step();
    dx_instr = '0;
    step();
    check("t1_count", 32'(s0_cnt), 32'd1);

    // blocking mult r6, result five cycles after start
    c0 = int'(s0_cnt); c1 = int'(s1_cnt);
    dx_instr = mk_r(5'd6, 5'd1, 5'd2, 5'd6);
    fd_instr = mk_i(5'd5, 5'd8, 5'd1);
    step();
    dx_instr = '0;
    repeat (4) step();
    md_ready = 1'b1;
    step();
    md_ready = 1'b0;
    check("t2_wb_valid", 32'(s0_wbv), 32'd1);
    check("t2_wb_rd", 32'(s0_wbrd), 32'd6);
    step();
    check("t2_stall_cycles", 32'(int'(s0_cnt) - c0), 32'd6);
    check("t3_nb1_indep", 32'(int'(s1_cnt) - c1), 32'd0);

    // non-blocking div r7 with a dependent add r9,r7,r2 in FD
    c1 = int'(s1_cnt);
    dx_instr = mk_r(5'd7, 5'd1, 5'd2, 5'd7);
    fd_instr = mk_r(5'd9, 5'd7, 5'd2, 5'd0);
    step();
    dx_instr = '0;
    repeat (3) step();
    md_ready = 1'b1;
    step();
    md_ready = 1'b0;
    step();
    check("t3_nb1_dep_stalls", 32'(int'(s1_cnt) - c1), 32'd4);

    // div with exception; bex in FD during BUSY
    dx_instr = mk_r(5'd7, 5'd1, 5'd2, 5'd7);
    fd_instr = mk_i(5'd22, 5'd0, 5'd0);
    step();
    dx_instr = '0;
    check("t4_bex_stall", 32'(s1_stall), 32'd1);
    md_ready = 1'b1; md_exception = 1'b1;
    step();
    md_ready = 1'b0; md_exception = 1'b0;
    check("t4_exc_wb_rd", 32'(s0_wbrd), 32'd30);
    step();

    // flush with md in DX, then flush during BUSY
    fd_instr = '0;
    dx_instr = mk_r(5'd6, 5'd1, 5'd2, 5'd6);
    flush = 1'b1;
    #1;
    check("t5_flush_no_start", 32'(s0_start), 32'd0);
    step();
    check("t5_flush_idle", 32'(s0_busy), 32'd0);
    flush = 1'b0;
    step();
    dx_instr = '0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    md_ready = 1'b1;
    step();
    md_ready = 1'b0;
    check("t5_wb_after_flush", 32'(s0_wbv), 32'd1);
    step();

    // reset mid-op, then counter saturation and clear
    dx_instr = mk_r(5'd6, 5'd1, 5'd2, 5'd6);
    step();
    dx_instr = '0;
    step();
    do_reset();
    dx_instr = mk_i(5'd8, 5'd3, 5'd1);
    fd_instr = mk_r(5'd4, 5'd3, 5'd5, 5'd0);
    repeat (5) step();
    check("t6_sat_cnt2", 32'(s2_cnt), 32'd3);
    check("t6_cnt16", 32'(s0_cnt), 32'd5);
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    check("t6_clear_wins", 32'(s0_cnt), 32'd0);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      fd_instr     = rinstr();
      dx_instr     = rinstr();
      flush        = ($urandom_range(0, 9) == 0);
      md_ready     = ($urandom_range(0, 3) == 0);
      md_exception = ($urandom_range(0, 2) == 0);
      cnt_clear    = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
